// File: rtl/sram_model_core.sv
// Behavioural single-clock SRAM: one read port, one write port, backdoor-visible storage.
// Latency: write 1 edge; read 1 cycle when RAM_IS_SYNCHRONOUS=1, 0 cycles otherwise.
// Backpressure: none; every enabled access completes in the cycle it is presented.
//
// Ports:
//   ramclk     - sole clock, all state updates on its rising edge
//   n_rst      - asynchronous active-low reset (clears the read register only)
//   addr       - read address; also the write address when DUAL=0
//   addr_write - write address, used only when DUAL=1
//   wen / ren  - write / read enables (ren ignored in combinational-read mode)
//   wdat       - write data
//   rdat       - read data
module sram_model_core #(
    parameter int ADDR_WIDTH         = 8,
    parameter int DATA_WIDTH         = 8,
    parameter int RAM_IS_SYNCHRONOUS = 1,
    parameter int DUAL               = 0
) (
    input  logic                  ramclk,
    input  logic                  n_rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [ADDR_WIDTH-1:0] addr_write,
    input  logic                  wen,
    input  logic                  ren,
    input  logic [DATA_WIDTH-1:0] wdat,
    output logic [DATA_WIDTH-1:0] rdat
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Name and ascending range are relied on by hierarchical load/dump tasks.
    // Not reset, so contents loaded by a backdoor survive a reset pulse.
    logic [DATA_WIDTH-1:0] ram [0:DEPTH-1];

    logic [ADDR_WIDTH-1:0] waddr;

    assign waddr = (DUAL != 0) ? addr_write : addr;

    // Write process. Kept as a plain clocked block so a testbench may also
    // deposit values into ram hierarchically without a driver conflict.
    always @(posedge ramclk) begin
        if (n_rst && wen) begin
            ram[waddr] <= wdat;
        end
    end

    // Read path. The register samples ram before the write in the same edge
    // lands, which gives read-before-write on a same-word collision.
    generate
        if (RAM_IS_SYNCHRONOUS != 0) begin : g_sync_read
            logic [DATA_WIDTH-1:0] rdat_q;
            logic [DATA_WIDTH-1:0] rdat_d;

            assign rdat_d = ren ? ram[addr] : rdat_q;

            always_ff @(posedge ramclk or negedge n_rst) begin
                if (!n_rst) begin
                    rdat_q <= '0;
                end else begin
                    rdat_q <= rdat_d;
                end
            end

            assign rdat = rdat_q;
        end else begin : g_comb_read
            // Follows memory continuously, reset included.
            assign rdat = ram[addr];
        end
    endgenerate

    // Simulation-only guard against undefined addresses or data on enabled ports.
    always @(posedge ramclk) begin
        if (ren) begin
            assert (!$isunknown(addr))
                else $error("sram_model_core: X/Z on addr with ren=1");
        end
        if (wen) begin
            assert (!$isunknown(waddr))
                else $error("sram_model_core: X/Z on write address with wen=1");
            assert (!$isunknown(wdat))
                else $error("sram_model_core: X/Z on wdat with wen=1");
        end
    end

endmodule

// File: tb/tb_sram_model_core.sv
module tb_sram_model_core;

    logic       ramclk;
    logic       n_rst;
    logic [7:0] addr;
    logic [7:0] addr_write;
    logic       wen;
    logic       ren;
    logic [7:0] wdat;
    logic [7:0] rdat_s;
    logic [7:0] rdat_d;
    logic [7:0] rdat_c;

    int n_checks;
    int n_fail;

    // Synchronous read, single address
    sram_model_core #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RAM_IS_SYNCHRONOUS(1), .DUAL(0)) u_sync (
        .ramclk(ramclk), .n_rst(n_rst), .addr(addr), .addr_write(addr_write),
        .wen(wen), .ren(ren), .wdat(wdat), .rdat(rdat_s)
    );

    // Synchronous read, separate write address
    sram_model_core #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RAM_IS_SYNCHRONOUS(1), .DUAL(1)) u_dual (
        .ramclk(ramclk), .n_rst(n_rst), .addr(addr), .addr_write(addr_write),
        .wen(wen), .ren(ren), .wdat(wdat), .rdat(rdat_d)
    );

    // Combinational read, single address
    sram_model_core #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RAM_IS_SYNCHRONOUS(0), .DUAL(0)) u_comb (
        .ramclk(ramclk), .n_rst(n_rst), .addr(addr), .addr_write(addr_write),
        .wen(wen), .ren(ren), .wdat(wdat), .rdat(rdat_c)
    );

    initial begin
        ramclk = 1'b0;
        forever #5 ramclk = ~ramclk;
    end

    typedef struct {
        logic       wen;
        logic       ren;
        logic [7:0] addr;
        logic [7:0] aw;
        logic [7:0] wdat;
        logic [7:0] exp_s;
        logic [7:0] exp_d;
        logic [7:0] exp_c;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic w, input logic r, input logic [7:0] a,
                         input logic [7:0] aw, input logic [7:0] d);
        wen        = w;
        ren        = r;
        addr       = a;
        addr_write = aw;
        wdat       = d;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        n_rst    = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);

        // Background pattern ram[i] = i ^ 0x5A, plus two preloaded words.
        for (int i = 0; i < 256; i++) begin
            u_sync.ram[i] = 8'(i) ^ 8'h5A;
            u_dual.ram[i] = 8'(i) ^ 8'h5A;
            u_comb.ram[i] = 8'(i) ^ 8'h5A;
        end
        u_sync.ram[5] = 8'h11; u_dual.ram[5] = 8'h11; u_comb.ram[5] = 8'h11;
        u_sync.ram[2] = 8'h99; u_dual.ram[2] = 8'h99; u_comb.ram[2] = 8'h99;

        // Row fields: wen ren addr addr_write wdat | exp sync, dual, comb (after the edge)
        tbl[0]  = '{1'b1, 1'b0, 8'h03, 8'h09, 8'hA5, 8'h00, 8'h00, 8'hA5}; // write, rdat still reset value
        tbl[1]  = '{1'b0, 1'b1, 8'h03, 8'h09, 8'h00, 8'hA5, 8'h59, 8'hA5}; // read back next cycle
        tbl[2]  = '{1'b0, 1'b0, 8'h09, 8'h09, 8'h00, 8'hA5, 8'h59, 8'h53}; // ren=0 holds
        tbl[3]  = '{1'b0, 1'b1, 8'h09, 8'h09, 8'h00, 8'h53, 8'hA5, 8'h53}; // dual saw write at 9
        tbl[4]  = '{1'b1, 1'b1, 8'h05, 8'h05, 8'h22, 8'h11, 8'h11, 8'h22}; // read-before-write
        tbl[5]  = '{1'b0, 1'b1, 8'h05, 8'h05, 8'h00, 8'h22, 8'h22, 8'h22}; // new data next read
        tbl[6]  = '{1'b1, 1'b1, 8'h02, 8'h07, 8'h3C, 8'h99, 8'h99, 8'h3C}; // independent r/w
        tbl[7]  = '{1'b0, 1'b1, 8'h07, 8'h00, 8'h00, 8'h5D, 8'h3C, 8'h5D};
        tbl[8]  = '{1'b0, 1'b1, 8'h02, 8'h00, 8'h00, 8'h3C, 8'h99, 8'h3C};
        tbl[9]  = '{1'b1, 1'b0, 8'h80, 8'hFF, 8'hC3, 8'h3C, 8'h99, 8'hC3}; // top address write
        tbl[10] = '{1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, 8'hA5, 8'hC3, 8'hA5};
        tbl[11] = '{1'b0, 1'b1, 8'h80, 8'h00, 8'h00, 8'hC3, 8'hDA, 8'hC3};
        tbl[12] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h5A, 8'h5A, 8'h5A}; // address 0

        // Reset: read registers clear, combinational port shows memory
        #1 n_rst = 1'b0;
        #1;
        check("reset_sync", rdat_s, 8'h00);
        check("reset_dual", rdat_d, 8'h00);
        check("reset_comb", rdat_c, 8'h5A);
        @(posedge ramclk);
        @(posedge ramclk);
        #1 n_rst = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].wen, tbl[i].ren, tbl[i].addr, tbl[i].aw, tbl[i].wdat);
            @(posedge ramclk);
            #2;
            check($sformatf("row%0d_sync", i), rdat_s, tbl[i].exp_s);
            check($sformatf("row%0d_dual", i), rdat_d, tbl[i].exp_d);
            check($sformatf("row%0d_comb", i), rdat_c, tbl[i].exp_c);
        end

        // Hold over several edges, then asynchronous reset mid-cycle
        drive(1'b0, 1'b1, 8'h03, 8'h00, 8'h00);
        @(posedge ramclk);
        #2;
        check("hold_read_sync", rdat_s, 8'hA5);
        drive(1'b0, 1'b0, 8'h09, 8'h00, 8'h00);
        repeat (3) @(posedge ramclk);
        #2;
        check("hold_sync", rdat_s, 8'hA5);
        check("hold_dual", rdat_d, 8'h59);
        #1 n_rst = 1'b0;
        #1;
        check("async_rst_sync", rdat_s, 8'h00);
        check("async_rst_dual", rdat_d, 8'h00);
        check("async_rst_comb", rdat_c, 8'h53);

        // Writes ignored during reset; register held at zero across an edge
        drive(1'b1, 1'b1, 8'h03, 8'h03, 8'hEE);
        @(posedge ramclk);
        #2;
        check("rst_hold_sync", rdat_s, 8'h00);
        check("rst_nowrite_comb", rdat_c, 8'hA5);

        // Backdoor load during reset survives release
        drive(1'b0, 1'b0, 8'h0A, 8'h00, 8'h00);
        u_sync.ram[10] = 8'h7E; u_dual.ram[10] = 8'h7E; u_comb.ram[10] = 8'h7E;
        #1;
        check("backdoor_rst_sync", rdat_s, 8'h00);
        check("backdoor_comb", rdat_c, 8'h7E);
        @(posedge ramclk);
        #1 n_rst = 1'b1;
        ren = 1'b1;
        @(posedge ramclk);
        #2;
        check("backdoor_sync", rdat_s, 8'h7E);
        check("backdoor_dual", rdat_d, 8'h7E);
        drive(1'b0, 1'b1, 8'h03, 8'h00, 8'h00);
        @(posedge ramclk);
        #2;
        check("rst_nowrite_sync", rdat_s, 8'hA5);
        check("rst_nowrite_dual", rdat_d, 8'h59);

        // Combinational read follows addr with no clock edge in between
        @(negedge ramclk);
        drive(1'b0, 1'b0, 8'h03, 8'h00, 8'h00);
        #1;
        check("comb_addr3", rdat_c, 8'hA5);
        addr = 8'h05;
        #1;
        check("comb_addr5", rdat_c, 8'h22);
        check("comb_sync_unchanged", rdat_s, 8'hA5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
